instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
//
// PURPOSE
//   Initiator side of the single-cycle instruction memory port. Drives addr/enable/wr into
//   the 16-bit byte-addressed instruction memory and captures its zero-delay combinational
//   read data. Fetched words are buffered in a small prefetch FIFO and handed to decode over
//   a valid/ready handshake. Supports branch redirect (flush) and halt.
//
// PARAMETERS
//   ADDR_WIDTH  16       width of PC and imem_addr
//   RESET_PC    16'h0000 PC loaded on reset; bit 0 must be 0
//   FIFO_DEPTH  4        prefetch entries; power of 2, >= 2
//
// PORTS
//   clk             in   1           clock, all state updates on rising edge
//   rst             in   1           reset, synchronous, active-high
//   imem_addr       out  ADDR_WIDTH  byte address to memory; bit 0 always 0
//   imem_enable     out  1           memory enable (read strobe)
//   imem_wr         out  1           memory write; constant 0
//   imem_data       in   16          memory read data, valid same cycle as enable
//   redirect_valid  in   1           flush FIFO and load new PC
//   redirect_pc     in   ADDR_WIDTH  target PC for redirect
//   halt_req        in   1           stop issuing fetches
//   instr_valid     out  1           FIFO head holds an instruction
//   instr           out  16          FIFO head instruction word
//   instr_pc        out  ADDR_WIDTH  PC of FIFO head
//   instr_ready     in   1           decode accepts head this cycle
//
// BEHAVIOUR
//   - Reset: pc<=RESET_PC, FIFO empty (count=0), state<=START. While rst=1: imem_enable=0,
//     instr_valid=0, imem_addr=0 (memory image loads during reset; must not be read).
//   - FSM: START -> FETCH unconditionally (one idle cycle after reset, enable=0).
//     FETCH -> HALTED when halt_req=1 (no fetch issued that cycle).
//     HALTED -> FETCH only on redirect_valid; halt_req ignored while HALTED.
//     redirect_valid in any non-reset state goes to FETCH.
//   - Fetch: in FETCH, with no redirect and no halt_req, and (count<FIFO_DEPTH or pop this
//     cycle): imem_enable=1, imem_addr=pc. imem_data is written into FIFO tail with pc at the
//     same clock edge, and pc<=pc+2 (mod 2^ADDR_WIDTH; 0xFFFE wraps to 0x0000).
//     Zero-latency fetch: word at PC P is visible on instr one cycle after addr=P is driven.
//   - Full: count==FIFO_DEPTH and no pop -> imem_enable=0, pc holds.
//     Full with pop -> fetch proceeds; count unchanged.
//   - Handshake: instr_valid = (count!=0). Pop when instr_valid & instr_ready. instr/instr_pc
//     are stable while instr_valid=1 and instr_ready=0.
//   - Redirect (highest priority): count<=0, pc<=redirect_pc with bit 0 cleared,
//     imem_enable=0 that cycle. A pop in the same cycle is accepted by decode; the flush still
//     empties FIFO. The first fetch at the new PC occurs the next cycle.
//   - Simultaneous push and pop: count unchanged, both pointers advance (mod FIFO_DEPTH).
//   - Mid-operation rst: identical to power-on reset; all FIFO contents discarded.
//
// CONFIGURATION
//   IFU_MISALIGN_ERR_EN defined: adds output misalign_err (1 bit). It is set on a redirect
//     with redirect_pc[0]=1 and is sticky until rst (reset value 0). Bit 0 is still cleared.
//   IFU_MISALIGN_ERR_EN undefined: no misalign_err port; bit 0 of redirect_pc is silently
//     cleared.
//
// TESTING
//   - Reset release, instr_ready=1, mem[0..3]=1111,2222,3333,4444 -> cycle0 enable=0;
//     addr 0,2,4,6 on cycles 1-4; instr 1111@pc0, then 2222@pc2, one per cycle.
//   - instr_ready=0 for 10 cycles -> exactly 4 fetches (addr 0..6), then enable=0 with
//     count=4. Raise ready -> 1111 presented first; a fetch of addr 8 issues in the same cycle.
//   - Redirect to 0x0040 while FIFO is full -> instr_valid=0 next cycle;
//     enable=0 in the redirect cycle; addr=0x0040 on the following cycle.
//   - Redirect to 0xFFFC with ready=1 -> fetches 0xFFFC, 0xFFFE, 0x0000 (wrap).
//   - halt_req during FETCH -> no further enable; FIFO drains to instr_valid=0 and stays
//     there; redirect to 0x0010 resumes fetching at 0x0010.
//   - With IFU_MISALIGN_ERR_EN: redirect_pc=0x0021 -> addr=0x0020, misalign_err=1 until rst;
//     without the macro: addr=0x0020 and no error port.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: drives a zero-latency instruction memory and buffers fetched
// words in a prefetch FIFO toward decode. Optional misalign_err output: define IFU_MISALIGN_ERR_EN.
module instr_fetch_unit #(
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic                  imem_enable,
  output logic                  imem_wr,
  input  logic [15:0]           imem_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  halt_req,
  output logic                  instr_valid,
  output logic [15:0]           instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  instr_ready,
`ifdef IFU_MISALIGN_ERR_EN
  output logic                  misalign_err,
`endif
  output logic [1:0]            dbg_state
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    ST_START  = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [CW-1:0]           count_q, count_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [15:0]             fifo_instr_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]   fifo_pc_q    [FIFO_DEPTH];
`ifdef IFU_MISALIGN_ERR_EN
  logic                    misalign_q;
`endif

  logic pop;
  logic full;
  logic fetch;

  // rst gates the outputs combinationally: the memory image is still loading while it is high.
  assign instr_valid = !rst && (count_q != '0);
  assign pop         = instr_valid && instr_ready;
  assign full        = (count_q == CW'(FIFO_DEPTH));
  assign fetch       = !rst && (state_q == ST_FETCH) && !redirect_valid && !halt_req &&
                       (!full || pop);

  assign imem_enable = fetch;
  assign imem_addr   = rst ? '0 : pc_q;
  assign imem_wr     = 1'b0;
  assign instr       = fifo_instr_q[rd_ptr_q];
  assign instr_pc    = fifo_pc_q[rd_ptr_q];
  assign dbg_state   = state_q;
`ifdef IFU_MISALIGN_ERR_EN
  assign misalign_err = misalign_q;
`endif

  always_comb begin
    pc_d     = pc_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (redirect_valid) begin
      pc_d     = redirect_pc & ~ADDR_WIDTH'(1);
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (fetch) begin
        pc_d     = pc_q + ADDR_WIDTH'(2);
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(fetch) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_START;
      pc_q     <= RESET_PC & ~ADDR_WIDTH'(1);
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
`ifdef IFU_MISALIGN_ERR_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      pc_q     <= pc_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (redirect_valid) begin
        state_q <= ST_FETCH;
`ifdef IFU_MISALIGN_ERR_EN
        misalign_q <= misalign_q | redirect_pc[0];
`endif
      end else begin
        case (state_q)
          ST_START:  state_q <= ST_FETCH;
          ST_FETCH:  if (halt_req) state_q <= ST_HALTED;
          ST_HALTED: state_q <= ST_HALTED;
          default:   state_q <= ST_START;
        endcase
      end
      if (fetch) begin
        fifo_instr_q[wr_ptr_q] <= imem_data;
        fifo_pc_q[wr_ptr_q]    <= pc_q;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: combinational memory model, linear stimulus,
// immediate-assertion checks and a one-line summary.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic [15:0] imem_addr;
  logic        imem_enable;
  logic        imem_wr;
  logic [15:0] imem_data;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        halt_req;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_ready;
  logic [1:0]  dbg_state;
`ifdef IFU_MISALIGN_ERR_EN
  logic        misalign_err;
`endif

  int checks;
  int failures;
  int nf;

  instr_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_enable    (imem_enable),
    .imem_wr        (imem_wr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
`ifdef IFU_MISALIGN_ERR_EN
    .misalign_err   (misalign_err),
`endif
    .dbg_state      (dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: four fixed words, every other address reads addr ^ 16'hBEEF
  always_comb begin
    case (imem_addr)
      16'h0000: imem_data = 16'h1111;
      16'h0002: imem_data = 16'h2222;
      16'h0004: imem_data = 16'h3333;
      16'h0006: imem_data = 16'h4444;
      default:  imem_data = imem_addr ^ 16'hBEEF;
    endcase
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 16'h0000;
    halt_req = 1'b0;
    instr_ready = 1'b0;

    // reset state
    sample();
    chk("rst_enable", {15'd0, imem_enable}, 16'd0);
    chk("rst_valid",  {15'd0, instr_valid}, 16'd0);
    chk("rst_addr",   imem_addr, 16'h0000);
    chk("rst_wr",     {15'd0, imem_wr}, 16'd0);
    tick();

    // streaming fetch with ready high
    rst = 1'b0;
    instr_ready = 1'b1;
    sample();
    chk("c0_enable", {15'd0, imem_enable}, 16'd0);
    chk("c0_state",  {14'd0, dbg_state}, 16'd0);
    tick();
    sample();
    chk("c1_enable", {15'd0, imem_enable}, 16'd1);
    chk("c1_addr",   imem_addr, 16'h0000);
    chk("c1_valid",  {15'd0, instr_valid}, 16'd0);
    tick();
    sample();
    chk("c2_addr",   imem_addr, 16'h0002);
    chk("c2_valid",  {15'd0, instr_valid}, 16'd1);
    chk("c2_instr",  instr, 16'h1111);
    chk("c2_pc",     instr_pc, 16'h0000);
    tick();
    sample();
    chk("c3_addr",   imem_addr, 16'h0004);
    chk("c3_instr",  instr, 16'h2222);
    chk("c3_pc",     instr_pc, 16'h0002);
    tick();
    sample();
    chk("c4_addr",   imem_addr, 16'h0006);
    chk("c4_instr",  instr, 16'h3333);
    tick();

    // mid-operation reset
    rst = 1'b1;
    sample();
    chk("mrst_enable", {15'd0, imem_enable}, 16'd0);
    chk("mrst_valid",  {15'd0, instr_valid}, 16'd0);
    chk("mrst_addr",   imem_addr, 16'h0000);
    tick();

    // backpressure: ten cycles with ready low fill the FIFO with exactly four fetches
    rst = 1'b0;
    instr_ready = 1'b0;
    nf = 0;
    for (int i = 0; i < 10; i++) begin
      sample();
      if (imem_enable) begin
        chk("bp_addr", imem_addr, 16'(2 * nf));
        nf++;
      end
      tick();
    end
    chk("bp_fetches", 16'(nf), 16'd4);
    sample();
    chk("bp_valid", {15'd0, instr_valid}, 16'd1);
    chk("bp_instr", instr, 16'h1111);
    chk("bp_pc",    instr_pc, 16'h0000);
    chk("bp_full_enable", {15'd0, imem_enable}, 16'd0);
    tick();
    instr_ready = 1'b1;
    sample();
    chk("fullpop_enable", {15'd0, imem_enable}, 16'd1);
    chk("fullpop_addr",   imem_addr, 16'h0008);
    chk("fullpop_instr",  instr, 16'h1111);
    tick();
    instr_ready = 1'b0;
    sample();
    chk("full2_instr",  instr, 16'h2222);
    chk("full2_pc",     instr_pc, 16'h0002);
    chk("full2_enable", {15'd0, imem_enable}, 16'd0);
    tick();

    // redirect while full
    redirect_valid = 1'b1;
    redirect_pc = 16'h0040;
    sample();
    chk("redir_enable", {15'd0, imem_enable}, 16'd0);
    chk("redir_valid_before", {15'd0, instr_valid}, 16'd1);
    tick();
    redirect_valid = 1'b0;
    instr_ready = 1'b1;
    sample();
    chk("redir_valid_after", {15'd0, instr_valid}, 16'd0);
    chk("redir_enable_next", {15'd0, imem_enable}, 16'd1);
    chk("redir_addr_next",   imem_addr, 16'h0040);
    tick();
    sample();
    chk("redir_instr", instr, 16'hBEAF);
    chk("redir_pc",    instr_pc, 16'h0040);
    chk("redir_addr2", imem_addr, 16'h0042);
    tick();

    // wrap-around at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc = 16'hFFFC;
    sample();
    chk("wrap_redir_enable", {15'd0, imem_enable}, 16'd0);
    tick();
    redirect_valid = 1'b0;
    sample();
    chk("wrap_addr0", imem_addr, 16'hFFFC);
    chk("wrap_valid0", {15'd0, instr_valid}, 16'd0);
    tick();
    sample();
    chk("wrap_addr1",  imem_addr, 16'hFFFE);
    chk("wrap_instr1", instr, 16'h4113);
    chk("wrap_pc1",    instr_pc, 16'hFFFC);
    tick();
    sample();
    chk("wrap_addr2",  imem_addr, 16'h0000);
    chk("wrap_instr2", instr, 16'h4111);
    chk("wrap_pc2",    instr_pc, 16'hFFFE);
    tick();
    sample();
    chk("wrap_instr3", instr, 16'h1111);
    chk("wrap_pc3",    instr_pc, 16'h0000);
    tick();

    // halt: no more fetches, FIFO drains, held until redirect
    halt_req = 1'b1;
    sample();
    chk("halt_enable", {15'd0, imem_enable}, 16'd0);
    chk("halt_instr",  instr, 16'h2222);
    tick();
    sample();
    chk("halted_valid",  {15'd0, instr_valid}, 16'd0);
    chk("halted_enable", {15'd0, imem_enable}, 16'd0);
    chk("halted_state",  {14'd0, dbg_state}, 16'd2);
    tick();
    halt_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("halted_hold_enable", {15'd0, imem_enable}, 16'd0);
      chk("halted_hold_valid",  {15'd0, instr_valid}, 16'd0);
      tick();
    end
    redirect_valid = 1'b1;
    redirect_pc = 16'h0010;
    sample();
    chk("resume_redir_enable", {15'd0, imem_enable}, 16'd0);
    tick();
    redirect_valid = 1'b0;
    sample();
    chk("resume_enable", {15'd0, imem_enable}, 16'd1);
    chk("resume_addr",   imem_addr, 16'h0010);
    tick();
    sample();
    chk("resume_instr", instr, 16'hBEFF);
    chk("resume_pc",    instr_pc, 16'h0010);
    tick();

    // misaligned redirect target
    redirect_valid = 1'b1;
    redirect_pc = 16'h0021;
    sample();
`ifdef IFU_MISALIGN_ERR_EN
    chk("mis_err_before", {15'd0, misalign_err}, 16'd0);
`endif
    tick();
    redirect_valid = 1'b0;
    sample();
    chk("mis_addr", imem_addr, 16'h0020);
`ifdef IFU_MISALIGN_ERR_EN
    chk("mis_err_set", {15'd0, misalign_err}, 16'd1);
`endif
    tick();
    sample();
    chk("mis_instr", instr, 16'hBECF);
    chk("mis_pc",    instr_pc, 16'h0020);
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 16'h0030;
    tick();
    redirect_valid = 1'b0;
    sample();
    chk("aligned_addr", imem_addr, 16'h0030);
`ifdef IFU_MISALIGN_ERR_EN
    chk("mis_err_sticky", {15'd0, misalign_err}, 16'd1);
`endif
    tick();
    rst = 1'b1;
    sample();
    chk("final_rst_enable", {15'd0, imem_enable}, 16'd0);
    chk("final_rst_valid",  {15'd0, instr_valid}, 16'd0);
    tick();
    rst = 1'b0;
    sample();
    chk("final_start_enable", {15'd0, imem_enable}, 16'd0);
`ifdef IFU_MISALIGN_ERR_EN
    chk("mis_err_cleared", {15'd0, misalign_err}, 16'd0);
`endif
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
